// File: rtl/clk_meas_pkg.sv
// Shared constants and FSM state encoding for the clock period meter.
package clk_meas_pkg;

    localparam int CNT_WIDTH_DEF   = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_DEF     = 65535;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_WAIT_EDGE = 2'd1;
    localparam state_t ST_MEASURE   = 2'd2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input plus a rising-edge detector
// on the synchronized level.
module sync_edge_detect
    import clk_meas_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_sync = sync_q[SYNC_STAGES-1];
    assign rise   = q_sync & ~prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk
// cycles, with a one-cycle update strobe and a loss-of-signal flag.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 meas_en,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 period_valid,
    output logic                 timeout
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

    logic s_sync, rise_evt;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic [CNT_WIDTH-1:0]   high_time_q, high_time_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;

    // Edge detection runs regardless of FSM state, so a level already high at
    // enable has been absorbed and cannot look like a fresh edge.
    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_async(sig_in),
        .q_sync (s_sync),
        .rise   (rise_evt)
    );

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path through
        // the case leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;

        if (!meas_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    state_d = ST_WAIT_EDGE;
                end
                ST_WAIT_EDGE: begin
                    if (rise_evt) begin
                        cnt_d   = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    // A coincident edge wins over the timeout; TIMEOUT caps cnt so it never wraps.
                    if (rise_evt) begin
                        period_d    = cnt_q;
                        high_time_d = hcnt_q;
                        valid_d     = 1'b1;
                        timeout_d   = 1'b0;
                        cnt_d       = CNT_ONE;
                        hcnt_d      = CNT_ONE;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        timeout_d = 1'b1;
                        state_d   = ST_WAIT_EDGE;
                    end else begin
                        cnt_d  = cnt_q + CNT_ONE;
                        hcnt_d = hcnt_q + {{(CNT_WIDTH-1){1'b0}}, s_sync};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: a 16-bit instance with TIMEOUT=20 and a
// 4-bit instance with TIMEOUT=15 sharing clock, reset and enable.
module tb_clk_period_meter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic meas_en = 1'b0;
    logic sig_in = 1'b0;
    logic sig_in2 = 1'b0;

    logic [15:0] period, high_time;
    logic        period_valid, timeout;
    logic [3:0]  period2, high_time2;
    logic        period_valid2, timeout2;

    int checks = 0;
    int errors = 0;

    // Results gathered by the stimulus tasks.
    int n_str, first_tick, bad, to_high, to_low_first, to_rise_tick;

    always #5 clk = ~clk;

    clk_period_meter #(
        .CNT_WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(20)
    ) dut (
        .clk(clk), .rst(rst), .meas_en(meas_en), .sig_in(sig_in),
        .period(period), .high_time(high_time),
        .period_valid(period_valid), .timeout(timeout)
    );

    clk_period_meter #(
        .CNT_WIDTH(4), .SYNC_STAGES(2), .TIMEOUT(15)
    ) dut4 (
        .clk(clk), .rst(rst), .meas_en(meas_en), .sig_in(sig_in2),
        .period(period2), .high_time(high_time2),
        .period_valid(period_valid2), .timeout(timeout2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int which, output logic v, output int p, output int h, output logic t);
        v = (which == 0) ? period_valid : period_valid2;
        p = (which == 0) ? int'(period) : int'(period2);
        h = (which == 0) ? int'(high_time) : int'(high_time2);
        t = (which == 0) ? timeout : timeout2;
    endtask

    // Drives a square wave of period per / high hi starting at phase start.
    // Strobes after the first skip are checked for value and spacing.
    task automatic run_wave(input int which, input int per, input int hi, input int start,
                            input int n, input logic en, input int skip);
        logic v, t;
        int   p, h;
        int   last_tick = 0;
        n_str = 0; first_tick = 0; bad = 0; to_high = 0; to_low_first = 0;
        for (int i = 0; i < n; i++) begin
            meas_en = en;
            if (which == 0) sig_in  = ((start + i) % per) < hi;
            else            sig_in2 = ((start + i) % per) < hi;
            tick();
            sample(which, v, p, h, t);
            if (t) to_high = 1;
            else if (to_low_first == 0) to_low_first = i + 1;
            if (v) begin
                n_str++;
                if (n_str == 1) first_tick = i + 1;
                if (n_str > skip) begin
                    if (p != per || h != hi) bad++;
                    if (n_str > skip + 1 && (i + 1 - last_tick) != per) bad++;
                end
                last_tick = i + 1;
            end
        end
    endtask

    task automatic hold_low(input int which, input int n);
        logic v, t;
        int   p, h;
        n_str = 0; to_rise_tick = 0;
        for (int i = 0; i < n; i++) begin
            if (which == 0) sig_in = 1'b0;
            else            sig_in2 = 1'b0;
            tick();
            sample(which, v, p, h, t);
            if (v) n_str++;
            if (t && to_rise_tick == 0) to_rise_tick = i + 1;
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rst_period", 32'(period), 0);
        check("rst_high", 32'(high_time), 0);
        check("rst_valid", 32'(period_valid), 0);
        check("rst_timeout", 32'(timeout), 0);
        rst = 1'b0;

        // 50% duty, period 10: first strobe SYNC_STAGES+1 after second edge (idx10 -> tick 13)
        run_wave(0, 10, 5, 0, 60, 1'b1, 0);
        check("sq_first_strobe", 32'(first_tick), 13);
        check("sq_num_strobes", 32'(n_str), 5);
        check("sq_values", 32'(bad), 0);
        check("sq_timeout", 32'(to_high), 0);

        // Asymmetric 3/8; the first strobe still spans the previous 10-cycle edge gap
        run_wave(0, 8, 3, 0, 48, 1'b1, 1);
        check("asym_num_strobes", 32'(n_str), 6);
        check("asym_values", 32'(bad), 0);
        check("asym_timeout", 32'(to_high), 0);

        // Loss of signal: last rise registered at wave tick 43, wave ended at 48
        hold_low(0, 30);
        check("los_timeout_tick", 32'(to_rise_tick), 15);
        check("los_no_strobe", 32'(n_str), 0);
        check("los_period_hold", 32'(period), 8);
        check("los_high_hold", 32'(high_time), 3);

        // Resume period 10: timeout clears together with the first strobe
        run_wave(0, 10, 5, 0, 40, 1'b1, 0);
        check("resume_first_strobe", 32'(first_tick), 13);
        check("resume_timeout_clear", 32'(to_low_first), 13);
        check("resume_num_strobes", 32'(n_str), 3);
        check("resume_values", 32'(bad), 0);

        // Disabled mid-measurement: no strobes, outputs hold
        run_wave(0, 10, 5, 0, 24, 1'b0, 0);
        check("dis_no_strobe", 32'(n_str), 0);
        check("dis_period_hold", 32'(period), 10);
        check("dis_high_hold", 32'(high_time), 5);
        check("dis_timeout_hold", 32'(timeout), 0);

        // Re-enable with sig_in already high: edges at idx6, idx16 -> first strobe tick 19
        run_wave(0, 10, 5, 4, 40, 1'b1, 0);
        check("reen_first_strobe", 32'(first_tick), 19);
        check("reen_num_strobes", 32'(n_str), 3);
        check("reen_values", 32'(bad), 0);

        // Reset midway through a period
        run_wave(0, 10, 5, 4, 4, 1'b1, 0);
        rst = 1'b1;
        sig_in = 1'b0;
        tick();
        check("mrst_period", 32'(period), 0);
        check("mrst_high", 32'(high_time), 0);
        check("mrst_timeout", 32'(timeout), 0);
        check("mrst_valid", 32'(period_valid), 0);
        rst = 1'b0;
        run_wave(0, 10, 5, 5, 40, 1'b1, 0);
        check("mrst_first_strobe", 32'(first_tick), 18);
        check("mrst_num_strobes", 32'(n_str), 3);
        check("mrst_values", 32'(bad), 0);

        // 4-bit counter, TIMEOUT=15: period 15 sits exactly on the limit
        sig_in = 1'b0;
        run_wave(1, 15, 7, 0, 60, 1'b1, 0);
        check("ext15_first_strobe", 32'(first_tick), 18);
        check("ext15_num_strobes", 32'(n_str), 3);
        check("ext15_values", 32'(bad), 0);
        check("ext15_timeout", 32'(to_high), 0);

        // Last rise registered at tick 48 of 60: timeout 15 cycles later
        hold_low(1, 20);
        check("ext_los_tick", 32'(to_rise_tick), 3);

        // Period 16 always exceeds the limit: timeout stays up, no strobe
        run_wave(1, 16, 8, 0, 64, 1'b1, 0);
        check("ext16_no_strobe", 32'(n_str), 0);
        check("ext16_timeout", 32'(to_low_first), 0);
        check("ext16_period_hold", 32'(period2), 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
Measures a slow, asynchronous square-wave input in units of the system clock. Reports the period (rising edge to rising edge) and the high time of each cycle, with a one-cycle valid strobe. It is the receive end of clk_divider: it checks any divided or external clock on the board without a scope. It sits between a divided or external clock source and the lab's display or register logic.

Parameters:
CNT_WIDTH, 16, width of the period and high-time counters and outputs
SYNC_STAGES, 2, flip-flop stages in the input synchronizer (minimum 2)
TIMEOUT, 65535, cycles without a rising edge before declaring loss of signal; must be at most 2^CNT_WIDTH-1

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
meas_en  input  1  measurement enable; level
sig_in  input  1  asynchronous signal under measurement
period  output  CNT_WIDTH  last measured period in clk cycles
high_time  output  CNT_WIDTH  clk cycles sig_in was high in that period
period_valid  output  1  one-cycle strobe when period and high_time update
timeout  output  1  level; no rising edge seen within TIMEOUT cycles

Behaviour:
- Interface (already decided): one clock, clk; reset is rst, synchronous and active-high.
- Reset values: period=0, high_time=0, period_valid=0, timeout=0. Synchronizer and edge flops are 0; FSM state is IDLE.
- Synchronizer: sig_in passes through SYNC_STAGES flops to give s_sync; one more flop gives s_prev.
- rise_evt = s_sync & ~s_prev.
- The edge detector runs in every state, so a sig_in that is already high at enable does not produce a false edge.
- Latency from a sig_in rising edge to rise_evt is SYNC_STAGES to SYNC_STAGES+1 cycles.
- IDLE: counters are held at 0.
  - meas_en=1 moves to WAIT_EDGE.
- WAIT_EDGE: counters are held.
  - rise_evt loads cnt=1 and hcnt=1, then moves to MEASURE.
  - The first edge after enable never produces period_valid.
- MEASURE:
  - Each cycle: cnt increments; hcnt increments only while s_sync=1.
  - On rise_evt:
    - period<=cnt and high_time<=hcnt.
    - period_valid=1 for exactly that one cycle.
    - timeout<=0.
    - cnt<=1 and hcnt<=1; stay in MEASURE.
  - If cnt==TIMEOUT and there is no rise_evt in the same cycle:
    - timeout<=1 and move to WAIT_EDGE.
    - period and high_time hold their last values; no strobe.
  - rise_evt takes priority over timeout when both occur in the same cycle.
- A steady signal of N cycles period and H cycles high gives period=N and high_time=H. The counters never wrap, because TIMEOUT caps them.
- meas_en=0 in any state:
  - Next state is IDLE and counters clear.
  - period, high_time and timeout hold; period_valid=0.
  - Re-enabling repeats the WAIT_EDGE step, so there is no stale partial measurement.
- rst mid-measurement: all registers return to reset values on the next clk edge. No strobe is issued for the aborted measurement.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package clk_meas_pkg:
  - FSM state encoding: IDLE, WAIT_EDGE, MEASURE.
  - Default constants for CNT_WIDTH, SYNC_STAGES and TIMEOUT.
- Sub-module sync_edge_detect:
  - Parameter SYNC_STAGES; ports clk, rst, d_async, q_sync, rise.
  - Reusable for any asynchronous lab inputs (buttons, external clocks).
- Counters, FSM and output registers live in clk_period_meter.

Test Plan:
- Square wave, 50% duty: rst=1 for 5 cycles, then meas_en=1 and sig_in toggling every 5 clk cycles (period 10). Required:
  - No strobe on the first edge.
  - First period_valid pulse a constant SYNC_STAGES+1 cycles after the second sig_in rising edge, with period=10 and high_time=5.
  - Every subsequent period_valid is 10 cycles apart with identical values.
- Asymmetric duty: sig_in high 3 cycles, low 5 cycles. Required: period=8 and high_time=3 on every strobe; timeout stays 0.
- Loss of signal: TIMEOUT=20; after a valid measurement, hold sig_in low. Required:
  - timeout=1 exactly 20 cycles after the last registered rise_evt.
  - period and high_time keep their old values.
  - After sig_in resumes with period 10: timeout clears on the second edge, together with a strobe of period=10.
- Enable gating:
  - meas_en=0 mid-period: period_valid stays 0 while disabled and outputs hold.
  - Re-enable while sig_in is already high: no strobe until two full rising edges have been seen, then period=10.
- Reset mid-operation: assert rst for 1 cycle midway through a period. Required:
  - On the next cycle, period=0, high_time=0, timeout=0 and period_valid=0.
  - After release with meas_en=1, the measurement resumes from WAIT_EDGE.
- Extreme period: CNT_WIDTH=4, TIMEOUT=15, sig_in period 15. Required: period=15 and timeout stays 0. With sig_in period 16: timeout=1 and no strobe.
